// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin N:1 arbiter/mux feeding a single registered
// output stage tagged with the source index.
// Optional packet lock: define ARB_PKT_LOCK_EN to hold the grant on one
// requester from its first beat through the beat marked in_last.

// Per-requester slice: eligibility, grant decode and AND-masked data.
module rr_mux_arbiter_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int SRC_W      = 2,
  parameter int IDX        = 0
) (
  input  logic                  valid,
  input  logic                  lock_vld,
  input  logic [SRC_W-1:0]      lock_idx,
  input  logic                  grant_vld,
  input  logic [SRC_W-1:0]      grant_idx,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  elig,
  output logic                  gnt,
  output logic [DATA_WIDTH-1:0] data_masked
);
  localparam logic [SRC_W-1:0] MY_IDX = SRC_W'(IDX);

  // While a packet is locked only the owning lane may compete.
  assign elig        = valid && (!lock_vld || (lock_idx == MY_IDX));
  assign gnt         = grant_vld && (grant_idx == MY_IDX);
  assign data_masked = gnt ? data : '0;
endmodule

module rr_mux_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  in_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_REQ-1:0]                  in_last,
  output logic [NUM_REQ-1:0]                  in_ready,
  output logic                                out_valid,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [SRC_W-1:0]                    out_src,
  input  logic                                out_ready
);
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [SRC_W-1:0]      out_src_q,   out_src_d;
  logic [SRC_W-1:0]      rr_ptr_q,    rr_ptr_d;
  logic                  lock_vld;
  logic [SRC_W-1:0]      lock_idx;

`ifdef ARB_PKT_LOCK_EN
  logic                  lock_vld_q, lock_vld_d;
  logic [SRC_W-1:0]      lock_idx_q, lock_idx_d;
  assign lock_vld = lock_vld_q;
  assign lock_idx = lock_idx_q;
`else
  logic                  unused_in_last;
  assign lock_vld       = 1'b0;
  assign lock_idx       = '0;
  assign unused_in_last = ^in_last;
`endif

  logic [NUM_REQ-1:0]                 elig;
  logic [NUM_REQ-1:0]                 gnt;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_masked;
  logic                               grant_vld;
  logic [SRC_W-1:0]                   grant_idx;
  logic [SRC_W-1:0]                   next_ptr;
  logic [DATA_WIDTH-1:0]              mux_data;
  logic                               load_en;
  logic                               accept;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    rr_mux_arbiter_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .SRC_W      (SRC_W),
      .IDX        (i)
    ) u_lane (
      .valid       (in_valid[i]),
      .lock_vld    (lock_vld),
      .lock_idx    (lock_idx),
      .grant_vld   (grant_vld),
      .grant_idx   (grant_idx),
      .data        (in_data[i]),
      .elig        (elig[i]),
      .gnt         (gnt[i]),
      .data_masked (data_masked[i])
    );
  end

  // Rotating priority search: first eligible lane at or after rr_ptr, wrapping.
  always_comb begin
    logic [SRC_W:0] pos;
    grant_vld = 1'b0;
    grant_idx = '0;
    pos       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (pos >= (SRC_W+1)'(NUM_REQ)) pos = pos - (SRC_W+1)'(NUM_REQ);
      if (!grant_vld && elig[pos[SRC_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = pos[SRC_W-1:0];
      end
    end
  end

  // AND-OR collapse of the one-hot masked lane data.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_REQ; i++) mux_data = mux_data | data_masked[i];
  end

  // Output stage can take a beat when empty or draining this cycle;
  // rst_n gating keeps in_ready low for the whole reset window.
  assign load_en  = !out_valid_q || out_ready;
  assign in_ready = gnt & {NUM_REQ{load_en && rst_n}};
  assign accept   = |in_ready;
  assign next_ptr = (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

  // Next-state for output register, pointer and packet lock.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef ARB_PKT_LOCK_EN
    lock_vld_d  = lock_vld_q;
    lock_idx_d  = lock_idx_q;
`endif
    if (load_en) out_valid_d = accept;
    if (accept) begin
      out_data_d = mux_data;
      out_src_d  = grant_idx;
`ifdef ARB_PKT_LOCK_EN
      // Pointer only moves once the packet completes.
      if (in_last[grant_idx]) begin
        lock_vld_d = 1'b0;
        rr_ptr_d   = next_ptr;
      end else begin
        lock_vld_d = 1'b1;
        lock_idx_d = grant_idx;
      end
`else
      rr_ptr_d   = next_ptr;
`endif
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
`ifdef ARB_PKT_LOCK_EN
      lock_vld_q  <= 1'b0;
      lock_idx_q  <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef ARB_PKT_LOCK_EN
      lock_vld_q  <= lock_vld_d;
      lock_idx_q  <= lock_idx_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (NUM_REQ=4, DATA_WIDTH=32).
module tb_rr_mux_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int S = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         in_valid;
  logic [N-1:0][W-1:0]  in_data;
  logic [N-1:0]         in_last;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic [W-1:0]         out_data;
  logic [S-1:0]         out_src;
  logic                 out_ready;

  int n_cmp = 0;
  int n_err = 0;

  rr_mux_arbiter #(.DATA_WIDTH(W), .NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_data(input int i);
    return (i == 2) ? 32'hDEAD_BEEF : (32'hA000_0000 | W'(i));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input int src);
    chk({tag, "_vld"},  64'(out_valid), 64'(v));
    chk({tag, "_src"},  64'(out_src),   64'(src));
    chk({tag, "_data"}, 64'(out_data),  64'(exp_data(src)));
  endtask

  // One posedge then a small settle delay; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i] = exp_data(i);

    // Reset, idle
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_vld",  64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data),  64'd0);
      chk("rst_src",  64'(out_src),   64'd0);
      chk("rst_rdy",  64'(in_ready),  64'd0);
    end
    in_valid = 4'b1111;
    #1;
    chk("rst_rdy_busy", 64'(in_ready), 64'd0);
    in_valid = '0;
    rst_n    = 1'b1;

    // Single request from lane 2
    in_valid = 4'b0100;
    #1;
    chk("single_rdy", 64'(in_ready), 64'b0100);
    tick();
    in_valid = 4'b1001;
    #1;
    chk_out("single", 1'b1, 2);
    chk("ptr3_rdy", 64'(in_ready), 64'b1000);  // pointer now at 3
    in_valid = '0;
    tick();
    chk_out("drain", 1'b0, 2);                 // data/src hold after drain

    // Fresh reset, then round-robin with all lanes requesting
    rst_n = 1'b0;
    #1;
    rst_n    = 1'b1;
    in_valid = 4'b1111;
    #1;
    chk("rr_rdy0", 64'(in_ready), 64'b0001);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_out($sformatf("rr%0d", k), 1'b1, k % 4);
    end

    // Back-pressure holding out_src=1
    out_ready = 1'b0;
    #1;
    chk("bp_rdy", 64'(in_ready), 64'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("bp_rdy_hold", 64'(in_ready), 64'd0);
      chk_out("bp_hold", 1'b1, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 64'(in_ready), 64'b0100);
    tick();
    chk_out("bp_next", 1'b1, 2);

    // Async reset between edges while a beat is held
    in_valid = '0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_vld",  64'(out_valid), 64'd0);
    chk("mrst_src",  64'(out_src),   64'd0);
    chk("mrst_data", 64'(out_data),  64'd0);
    in_valid = 4'b1000;
    #1;
    chk("mrst_rdy", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("mrst_rel_rdy", 64'(in_ready), 64'b1000);
    chk("mrst_rel_vld", 64'(out_valid), 64'd0);
    tick();
    chk_out("mrst_acc", 1'b1, 3);

    // Move pointer to 1, then lane 1 sends a 3-beat packet with all lanes valid
    in_valid = 4'b0001;
    tick();
    chk_out("pre_pkt", 1'b1, 0);
    in_valid = 4'b1111;
    in_last  = 4'b0000;
    tick();
    chk_out("pkt_b0", 1'b1, 1);
`ifdef ARB_PKT_LOCK_EN
    chk("pkt_lock_rdy", 64'(in_ready), 64'b0010);
`else
    chk("pkt_lock_rdy", 64'(in_ready), 64'b0100);
`endif
    tick();
`ifdef ARB_PKT_LOCK_EN
    chk_out("pkt_b1", 1'b1, 1);
`else
    chk_out("pkt_b1", 1'b1, 2);
`endif
    in_last = 4'b0010;
    tick();
`ifdef ARB_PKT_LOCK_EN
    chk_out("pkt_b2", 1'b1, 1);
`else
    chk_out("pkt_b2", 1'b1, 3);
`endif
    in_last = 4'b0000;
    tick();
`ifdef ARB_PKT_LOCK_EN
    chk_out("pkt_after", 1'b1, 2);
`else
    chk_out("pkt_after", 1'b1, 0);
`endif

    in_valid = '0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one N:1 data path among NUM_REQ requesters using valid/ready handshakes.
- Selects a winner, steers its data through the N-way select, and registers it into a single output stage with a source tag.
- Sits between several producers (e.g. fetch, LSU, debug) and one shared consumer port (bus/memory request channel).

Parameters:
- DATA_WIDTH, 32, width of each requester's payload.
- NUM_REQ, 4, number of requesters; legal range 1..16.
- SRC_W, $clog2(NUM_REQ) (minimum 1), width of source index / round-robin pointer.

Ports:
- clk  input  1  clock; all state rises on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_REQ  per-requester request valid.
- in_data  input  NUM_REQ x DATA_WIDTH  packed per-requester payload; index i is requester i.
- in_last  input  NUM_REQ  last beat of packet; used only with ARB_PKT_LOCK_EN, ignored otherwise.
- in_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- out_valid  output  1  registered output holds a beat.
- out_data  output  DATA_WIDTH  registered payload of the accepted beat.
- out_src  output  SRC_W  index of the requester that supplied out_data.
- out_ready  input  1  consumer accepts the output beat.

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_data=0, out_src=0, rr_ptr=0, lock cleared. While rst_n=0, in_ready=0 regardless of inputs.
- load_en = !out_valid || out_ready. The output register may load in the same cycle it drains, giving 1 beat/cycle throughput.
- Winner: first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... NUM_REQ-1, then wrapping to 0 .. rr_ptr-1.
- in_ready[winner] = load_en && any in_valid. All other in_ready bits = 0. in_ready may depend combinationally on in_valid and out_ready.
- Accept: in_valid[g] && in_ready[g]. On the next edge: out_valid<=1, out_data<=in_data[g], out_src<=g.
- Latency: accept-to-out_valid is 1 cycle.
- Drain with no accept: out_valid && out_ready && no winner, so out_valid<=0. out_data and out_src hold their last values.
- Stall: out_valid && !out_ready, so load_en=0, all in_ready=0, and out_* hold stable.
- Pointer: on accept of g (and, with lock, only on release), rr_ptr <= g+1, wrapping to 0 when g=NUM_REQ-1. rr_ptr holds when there is no accept.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 accepts before being granted.
- NUM_REQ=1: the pointer stays 0, in_ready[0]=load_en, and out_src=0.
- A requester dropping in_valid before being granted is not an error. Nothing is latched until accept.
- Reset asserted mid-transfer: the held beat is discarded. No beat is emitted after release until a new accept occurs.

Optional Feature:
- Macro: ARB_PKT_LOCK_EN.
- Defined: a lock register (lock_vld, lock_idx) is set when a beat with in_last=0 is accepted from g.
- While lock_vld=1, only lock_idx is eligible; other requesters get in_ready=0 even if the locked requester is idle.
- Accepting a beat from lock_idx with in_last=1 clears the lock and advances rr_ptr to lock_idx+1 at that point only.
- A single-beat packet (in_last=1 on the first beat) behaves as unlocked. Reset clears the lock.
- Undefined: no lock state exists, in_last is ignored, and every accepted beat advances rr_ptr.

Test Plan:
- Reset then idle (rst_n low 3 cycles, all in_valid=0) -> out_valid=0, out_data=0, out_src=0, in_ready=0000 throughout.
- Single request: in_valid=0100, in_data[2]=32'hDEAD_BEEF, out_ready=1 -> in_ready=0100 in the same cycle; next cycle out_valid=1, out_data=DEAD_BEEF, out_src=2. rr_ptr then equals 3.
- Round-robin: in_valid=1111 held, out_ready=1, starting from reset -> out_src sequence 0,1,2,3,0,1 on consecutive cycles with out_valid continuously 1.
- Back-pressure: out_valid=1 with out_src=1, out_ready=0 for 4 cycles, in_valid=1111 -> in_ready=0000 and out_data/out_src stable. Raise out_ready -> next output is out_src=2.
- Mid-stream async reset: pulse rst_n low between clock edges while out_valid=1 -> out_valid=0 immediately. After release with in_valid=1000 -> out_src=3, one cycle after accept.
- ARB_PKT_LOCK_EN: requester 1 sends 3 beats (in_last=0,0,1) while in_valid=1111 -> out_src=1,1,1 and requester 2 is blocked. Next grant goes to requester 2. Without the macro, the same stimulus gives out_src=1,2,3.
